// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with stall/flush, write-back select and perf counters
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold the stage / replace it with a bubble (flush wins)
//   *_in                  MEM-stage slot: valid, reg-write enable, wb select, load data,
//                         ALU result, PC, destination register
//   *_out                 registered copies; w_reg_ctl_out is qualified by valid and $zero
//   wb_data_out           write-back value selected from the registered fields
//   retire_count          valid instructions loaded into WB (wraps)
//   stall_count           stalled edges (saturates)

module mem_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_OFF = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              w_reg_ctl_in,
    input  logic [1:0]        mem_to_reg_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] pc_value_in,
    input  logic [ADDR_W-1:0] w_reg_addr_in,
    output logic              valid_out,
    output logic              w_reg_ctl_out,
    output logic [1:0]        mem_to_reg_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] pc_value_out,
    output logic [ADDR_W-1:0] w_reg_addr_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [DATA_W-1:0] LINK_ADD = DATA_W'(LINK_OFF);

    // Writes to $zero are dropped here so forwarding never sees them as live.
    logic w_reg_ctl_qual;
    assign w_reg_ctl_qual = w_reg_ctl_in & valid_in & (w_reg_addr_in != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out      <= 1'b0;
            w_reg_ctl_out  <= 1'b0;
            mem_to_reg_out <= 2'b00;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            pc_value_out   <= '0;
            w_reg_addr_out <= '0;
            retire_count   <= '0;
            stall_count    <= '0;
        end else if (flush) begin
            valid_out      <= 1'b0;
            w_reg_ctl_out  <= 1'b0;
            mem_to_reg_out <= 2'b00;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            pc_value_out   <= '0;
            w_reg_addr_out <= '0;
        end else if (stall) begin
            if (stall_count != CNT_MAX) begin
                stall_count <= stall_count + 1'b1;
            end
        end else begin
            valid_out      <= valid_in;
            w_reg_ctl_out  <= w_reg_ctl_qual;
            mem_to_reg_out <= mem_to_reg_in;
            mem_data_out   <= mem_data_in;
            alu_result_out <= alu_result_in;
            pc_value_out   <= pc_value_in;
            w_reg_addr_out <= w_reg_addr_in;
            if (valid_in) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    // Driven only from registers, so there is no input-to-output path.
    always_comb begin
        wb_data_out = '0;
        case (mem_to_reg_out)
            2'b00:   wb_data_out = alu_result_out;
            2'b01:   wb_data_out = mem_data_out;
            2'b10:   wb_data_out = pc_value_out + LINK_ADD;
            default: wb_data_out = '0;
        endcase
    end

endmodule
